// File: rtl/seq_mul_if.sv
// rtl/seq_mul_if.sv - start/busy/done handshake bundle for the sequential multiplier
interface seq_mul_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mul_module.sv
// rtl/seq_mul_module.sv - shift-and-add unsigned multiplier, one partial-product add per clock
module seq_mul_ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    logic [WIDTH:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    assign Cout = c[WIDTH];
endmodule

module seq_mul_module #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_mul_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    assign addend = lo[0] ? m : '0;

    seq_mul_ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .A    (hi),
        .B    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a new request exactly like IDLE for back-to-back issue
                    done <= 1'b0;
                    if (bus.start) begin
                        m     <= bus.a;
                        hi    <= '0;
                        lo    <= bus.b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // carry-out becomes the new MSB so no product bit is lost
                    hi  <= {cout, sum[WIDTH-1:1]};
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        product <= {cout, sum, lo[WIDTH-1:1]};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
endmodule

// File: tb/tb_seq_mul_module.sv
// tb/tb_seq_mul_module.sv - scoreboard bench for seq_mul_module at WIDTH 8 and 32
module tb_seq_mul_module;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mul_if #(.WIDTH(8))  bus8 ();
    seq_mul_if #(.WIDTH(32)) bus32 ();

    seq_mul_module #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    seq_mul_module #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    typedef struct {
        logic [15:0] p;
        int          due;
    } exp8_t;

    typedef struct {
        logic [63:0] p;
        int          due;
    } exp32_t;

    exp8_t  q8[$];
    exp32_t q32[$];
    exp8_t  e8;
    exp32_t e32;
    int          run8 = 0;
    int          run32 = 0;
    logic [15:0] last8 = '0;
    logic [63:0] last32 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // monitors: pop the oldest expectation whenever DONE is seen
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            run8  = 0;
            last8 = '0;
        end else begin
            if (bus8.busy) run8++;
            else if (run8 != 0) begin
                check("busy8_len", 64'(run8), 64'd8);
                run8 = 0;
            end
            if (bus8.done) begin
                check("done8_busy_low", 64'(bus8.busy), 64'd0);
                if (q8.size() == 0) flag("done8_unexpected");
                else begin
                    e8 = q8.pop_front();
                    check("product8", 64'(bus8.product), 64'(e8.p));
                    check("done8_cycle", 64'(cyc), 64'(e8.due));
                end
                last8 = bus8.product;
            end else begin
                check("hold8", 64'(bus8.product), 64'(last8));
                if (q8.size() > 0 && cyc > q8[0].due) begin
                    flag("done8_missing");
                    void'(q8.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            run32  = 0;
            last32 = '0;
        end else begin
            if (bus32.busy) run32++;
            else if (run32 != 0) begin
                check("busy32_len", 64'(run32), 64'd32);
                run32 = 0;
            end
            if (bus32.done) begin
                check("done32_busy_low", 64'(bus32.busy), 64'd0);
                if (q32.size() == 0) flag("done32_unexpected");
                else begin
                    e32 = q32.pop_front();
                    check("product32", bus32.product, e32.p);
                    check("done32_cycle", 64'(cyc), 64'(e32.due));
                end
                last32 = bus32.product;
            end else begin
                check("hold32", bus32.product, last32);
                if (q32.size() > 0 && cyc > q32[0].due) begin
                    flag("done32_missing");
                    void'(q32.pop_front());
                end
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        while (bus8.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus8.busy) flag("idle8_timeout");
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (bus32.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus32.busy) flag("idle32_timeout");
    endtask

    // called just after a negedge; the next rising edge accepts the request
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        wait_idle8();
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        q8.push_back('{p: {8'd0, a} * {8'd0, b}, due: cyc + 1 + 8});
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b);
        wait_idle32();
        bus32.start = 1'b1;
        bus32.a     = a;
        bus32.b     = b;
        q32.push_back('{p: {32'd0, a} * {32'd0, b}, due: cyc + 1 + 32});
        @(negedge clk);
        bus32.start = 1'b0;
        bus32.a     = $urandom;
        bus32.b     = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q32.size() != 0) flag("drain_timeout");
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand32(input int n);
        for (int i = 0; i < n; i++) begin
            issue32(pick32(), pick32());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic rand8(input int n);
        for (int i = 0; i < n; i++) begin
            issue8(pick8(), pick8());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    int c0;

    initial begin
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus32.start = 1'b0;
        bus32.a     = '0;
        bus32.b     = '0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy8", 64'(bus8.busy), 64'd0);
        check("rst_done8", 64'(bus8.done), 64'd0);
        check("rst_product8", 64'(bus8.product), 64'd0);
        check("rst_busy32", 64'(bus32.busy), 64'd0);
        check("rst_done32", 64'(bus32.done), 64'd0);
        check("rst_product32", bus32.product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue8(8'd3, 8'd5);
        drain();
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue32(32'd0, 32'hDEAD_BEEF);
        drain();
        repeat (5) @(negedge clk);
        issue32(32'h1234_5678, 32'd1);
        drain();

        // second request mid-RUN must be ignored
        issue8(8'd7, 8'd9);
        repeat (3) @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'd2;
        bus8.b     = 8'd2;
        @(negedge clk);
        bus8.start = 1'b0;
        drain();

        issue8(8'd77, 8'd33);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy8", 64'(bus8.busy), 64'd0);
        check("midrst_done8", 64'(bus8.done), 64'd0);
        check("midrst_product8", 64'(bus8.product), 64'd0);
        check("midrst_product32", bus32.product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue8(8'd10, 8'd10);
        drain();

        // START held high: second operation must be taken in the DONE cycle
        wait_idle8();
        c0 = cyc;
        bus8.start = 1'b1;
        bus8.a     = 8'd200;
        bus8.b     = 8'd200;
        q8.push_back('{p: 16'h9C40, due: c0 + 9});
        @(negedge clk);
        bus8.a = 8'd255;
        bus8.b = 8'd2;
        q8.push_back('{p: 16'd510, due: c0 + 18});
        repeat (8) @(negedge clk);
        check("b2b_done_cycle", 64'(bus8.done), 64'd1);
        @(negedge clk);
        bus8.start = 1'b0;
        drain();

        fork
            rand32(1000);
            rand8(300);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
